// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encoding for the 16x-oversampled receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int OVS        = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
  localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver on a 16x baud tick: mid-bit sampling, registered byte output,
// one-cycle done / framing-error strobes.
module uart_rx_os16
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_rx_busy,
  output logic       o_frame_err
);

  logic rx_s;

  uart_state_t state_reg, state_next;
  logic [3:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_reg, data_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        busy_reg, busy_next;

  uart_rx_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_rx),
    .q     (rx_s)
  );

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (baud_tick) begin
      case (state_reg)
        ST_IDLE: begin
          baud_cnt_next = 4'd0;
          bit_cnt_next  = 3'd0;
          if (!rx_s) begin
            state_next = ST_START;
          end
        end

        ST_START: begin
          // Start bit is re-checked at its centre; a short low pulse is dropped silently.
          if (baud_cnt_reg == MID_CNT) begin
            baud_cnt_next = 4'd0;
            state_next    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt_next = baud_cnt_reg + 4'd1;
          end
        end

        ST_DATA: begin
          if (baud_cnt_reg == OVS_LAST) begin
            shift_next[bit_cnt_reg] = rx_s;
            baud_cnt_next           = 4'd0;
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_next = 3'd0;
              state_next   = ST_STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else begin
            baud_cnt_next = baud_cnt_reg + 4'd1;
          end
        end

        ST_STOP: begin
          // Leave at mid-stop so a start edge immediately after the stop bit is caught.
          if (baud_cnt_reg == OVS_LAST) begin
            baud_cnt_next = 4'd0;
            state_next    = ST_IDLE;
            if (rx_s) begin
              data_next = shift_reg;
              done_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else begin
            baud_cnt_next = baud_cnt_reg + 4'd1;
          end
        end

        default: begin
          state_next    = ST_IDLE;
          baud_cnt_next = 4'd0;
          bit_cnt_next  = 3'd0;
        end
      endcase
    end

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= 4'd0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      data_reg     <= 8'h00;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
    end
  end

  assign o_rx_data   = data_reg;
  assign o_rx_done   = done_reg;
  assign o_frame_err = err_reg;
  assign o_rx_busy   = busy_reg;

endmodule
